adc_display_averager: RTL and testbench

- Sits directly upstream of the 4-digit seven-segment display driver and produces its 12-bit num input.
- Takes raw ADC samples qualified by a valid strobe from the ADC driver and averages a block of 2^AVG_LOG2 samples.
- Presents the truncated mean as a registered, stable value.
- Rate-limits display updates with a hold timer so digits stay readable; a freeze input holds the current reading.

---
 rtl/adc_display_averager_pkg.sv | 27 ++
 rtl/adc_display_averager_if.sv | 30 +++
 rtl/adc_display_averager_hold_timer.sv | 41 ++++
 rtl/adc_display_averager.sv | 123 ++++++++++++
 tb/tb_adc_display_averager.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/adc_display_averager_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_disp_pkg
// Description : Shared types, default constants and width helper for the
//               ADC display averager.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_disp_pkg;

    // Two-state controller: gathering samples, or dropping them while the
    // display is held steady.
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int DEF_SAMPLE_W    = 12;
    localparam int DEF_AVG_LOG2    = 4;
    localparam int DEF_HOLD_CYCLES = 5000000;

    // Sum of 2^avg_log2 samples of sample_w bits never exceeds this width.
    function automatic int acc_width(input int sample_w, input int avg_log2);
        return sample_w + avg_log2;
    endfunction

endpackage : adc_disp_pkg
`default_nettype wire

// File: rtl/adc_display_averager_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_display_averager_if
// Description : Sample-in / display-value-out bundle for the averager.
//               master = sample source / display side, slave = averager.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_display_averager_if
    import adc_disp_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W
);
    logic [SAMPLE_W-1:0] sample;
    logic                sample_valid;
    logic                freeze;
    logic [SAMPLE_W-1:0] num;
    logic                num_update;
    logic                busy_hold;

    modport master (
        output sample, sample_valid, freeze,
        input  num, num_update, busy_hold
    );

    modport slave (
        input  sample, sample_valid, freeze,
        output num, num_update, busy_hold
    );
endinterface : adc_display_averager_if
`default_nettype wire

// File: rtl/adc_display_averager_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : hold_timer
// Description : Loadable down-counter. Load sets the count to HOLD_CYCLES;
//               active while non-zero, expired while the count reads 1
//               (the last cycle of the hold window).
// Revision    : 1.0 - initial release
// ============================================================================
module hold_timer
    import adc_disp_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic expired,
    output logic active
);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] c_load_val = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] c_one      = CW'(1);

    logic [CW-1:0] r_count;

    // Reload on request, otherwise count down to zero and rest there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - c_one;
        end
    end

    assign active  = (r_count != '0);
    assign expired = (r_count == c_one);

endmodule : hold_timer
`default_nettype wire

// File: rtl/adc_display_averager.sv
`default_nettype none
// ============================================================================
// Module      : adc_display_averager
// Description : Block-averages 2^AVG_LOG2 ADC samples and publishes the
//               truncated mean as a registered display value, then ignores
//               samples for HOLD_CYCLES so the digits stay readable.
//               freeze suppresses publishing without disturbing the cadence.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_display_averager
    import adc_disp_pkg::*;
#(
    parameter int SAMPLE_W    = DEF_SAMPLE_W,
    parameter int AVG_LOG2    = DEF_AVG_LOG2,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    adc_display_averager_if.slave  bus
);
    localparam int ACC_W = acc_width(SAMPLE_W, AVG_LOG2);
    localparam int CNT_W = AVG_LOG2 + 1;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    // With no hold window the controller goes straight back to collecting.
    localparam state_t c_done_state = (HOLD_CYCLES > 0) ? HOLD : ACCUM;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic [ACC_W-1:0]    w_sum;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [SAMPLE_W-1:0] r_num;
    logic [SAMPLE_W-1:0] w_num_nxt;
    logic [SAMPLE_W-1:0] w_mean;
    logic                r_num_update;
    logic                w_num_update_nxt;
    logic                w_hold_load;
    logic                w_hold_expired;
    logic                w_hold_active;

    // Running sum including the sample on the bus; the mean is its top
    // SAMPLE_W bits, i.e. a truncating shift by AVG_LOG2.
    assign w_sum  = r_acc + ACC_W'(bus.sample);
    assign w_mean = w_sum[ACC_W-1:AVG_LOG2];

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_hold_load),
        .expired (w_hold_expired),
        .active  (w_hold_active)
    );

    // State, accumulator, sample count and published value registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ACCUM;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_num        <= '0;
            r_num_update <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_cnt        <= w_cnt_nxt;
            r_num        <= w_num_nxt;
            r_num_update <= w_num_update_nxt;
        end
    end

    // Next-state and datapath control: accept, complete a block, or hold.
    always_comb begin
        w_state_nxt      = r_state;
        w_acc_nxt        = r_acc;
        w_cnt_nxt        = r_cnt;
        w_num_nxt        = r_num;
        w_num_update_nxt = 1'b0;
        w_hold_load      = 1'b0;

        case (r_state)
            ACCUM: begin
                if (bus.sample_valid) begin
                    if (r_cnt == c_cnt_last) begin
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_hold_load = 1'b1;
                        w_state_nxt = c_done_state;
                        // freeze only matters here, at block completion.
                        if (!bus.freeze) begin
                            w_num_nxt        = w_mean;
                            w_num_update_nxt = 1'b1;
                        end
                    end else begin
                        w_acc_nxt = w_sum;
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
            end
            HOLD: begin
                // Samples are dropped; leave on the last hold cycle. An idle
                // timer also releases the state so it can never stick.
                if (w_hold_expired || !w_hold_active) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end

    assign bus.num        = r_num;
    assign bus.num_update = r_num_update;
    assign bus.busy_hold  = (r_state == HOLD);

endmodule : adc_display_averager
`default_nettype wire

// File: tb/tb_adc_display_averager.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_display_averager
// Description : Directed self-checking bench. Main instance: 16-sample
//               average, 10-cycle hold. Second instance: single-sample
//               average with no hold.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_display_averager;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    int   n_pulses;

    adc_display_averager_if #(.SAMPLE_W(12)) bus  ();
    adc_display_averager_if #(.SAMPLE_W(12)) bus0 ();

    adc_display_averager #(
        .SAMPLE_W    (12),
        .AVG_LOG2    (4),
        .HOLD_CYCLES (10)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    adc_display_averager #(
        .SAMPLE_W    (12),
        .AVG_LOG2    (0),
        .HOLD_CYCLES (0)
    ) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count update pulses on the main instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.num_update === 1'b1) n_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present n samples of one value, each for one edge, with optional gaps.
    task automatic send_const(input logic [11:0] value, input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            bus.sample       = value;
            bus.sample_valid = 1'b1;
            tick();
            bus.sample_valid = 1'b0;
            if (max_gap > 0 && i != n - 1) begin
                repeat ($urandom_range(0, max_gap)) tick();
            end
        end
    endtask

    task automatic wait_hold_end();
        int k;
        k = 0;
        while (bus.busy_hold === 1'b1 && k < 100) begin
            tick();
            k++;
        end
        if (bus.busy_hold !== 1'b0) check("hold_timeout", 32'(bus.busy_hold), 32'd0);
    endtask

    initial begin
        int p0;
        int hold_len;
        logic [11:0] vals0 [3];

        n_checks = 0;
        n_fail   = 0;
        n_pulses = 0;
        reset_n  = 1'b0;
        bus.sample = '0;  bus.sample_valid = 1'b0;  bus.freeze = 1'b0;
        bus0.sample = '0; bus0.sample_valid = 1'b0; bus0.freeze = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_num",  32'(bus.num), 32'h0);
        check("rst_upd",  32'(bus.num_update), 32'h0);
        check("rst_busy", 32'(bus.busy_hold), 32'h0);
        reset_n = 1'b1;
        tick();
        check("rst_exit_upd", 32'(bus.num_update), 32'h0);

        // Constant input, latency and hold length
        p0 = n_pulses;
        send_const(12'h800, 16, 0);
        check("const_num",  32'(bus.num), 32'h800);
        check("const_upd",  32'(bus.num_update), 32'h1);
        check("const_busy", 32'(bus.busy_hold), 32'h1);
        hold_len = 1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.busy_hold !== 1'b1) break;
            hold_len++;
        end
        check("hold_len", 32'(hold_len), 32'd10);
        check("const_pulses", 32'(n_pulses - p0), 32'd1);

        // Truncation: 8*1 + 8*2 = 24, 24>>4 = 1
        for (int i = 0; i < 16; i++) send_const((i % 2 == 0) ? 12'h001 : 12'h002, 1, 0);
        check("trunc_small", 32'(bus.num), 32'h001);
        wait_hold_end();
        // 15*0xFFF = 61425, 61425>>4 = 3839
        send_const(12'hFFF, 15, 0);
        send_const(12'h000, 1, 0);
        check("trunc_large", 32'(bus.num), 32'hEFF);
        wait_hold_end();

        // Gaps in sample_valid
        p0 = n_pulses;
        send_const(12'h123, 15, 5);
        check("gap_no_early", 32'(bus.num), 32'hEFF);
        repeat ($urandom_range(0, 5)) tick();
        send_const(12'h123, 1, 0);
        check("gap_num", 32'(bus.num), 32'h123);
        wait_hold_end();
        check("gap_pulses", 32'(n_pulses - p0), 32'd1);

        // Hold drop: 0xFFF presented throughout HOLD must be discarded
        send_const(12'h200, 16, 0);
        check("drop_pre_num", 32'(bus.num), 32'h200);
        bus.sample       = 12'hFFF;
        bus.sample_valid = 1'b1;
        wait_hold_end();
        send_const(12'h010, 16, 0);
        check("drop_num", 32'(bus.num), 32'h010);
        wait_hold_end();

        // Freeze
        send_const(12'h400, 16, 0);
        check("frz_blk1", 32'(bus.num), 32'h400);
        wait_hold_end();
        p0 = n_pulses;
        send_const(12'h7FF, 15, 0);
        bus.freeze = 1'b1;
        send_const(12'h7FF, 1, 0);
        check("frz_num",  32'(bus.num), 32'h400);
        check("frz_upd",  32'(bus.num_update), 32'h0);
        check("frz_busy", 32'(bus.busy_hold), 32'h1);
        wait_hold_end();
        check("frz_pulses", 32'(n_pulses - p0), 32'd0);
        bus.freeze = 1'b0;
        send_const(12'h7FF, 16, 0);
        check("unfrz_num", 32'(bus.num), 32'h7FF);
        check("unfrz_upd", 32'(bus.num_update), 32'h1);
        wait_hold_end();

        // Reset mid-accumulation
        send_const(12'h100, 9, 0);
        reset_n = 1'b0;
        #1;
        check("rstacc_num",  32'(bus.num), 32'h0);
        check("rstacc_busy", 32'(bus.busy_hold), 32'h0);
        tick();
        reset_n = 1'b1;
        send_const(12'h300, 15, 0);
        check("rstacc_no_early", 32'(bus.num), 32'h0);
        check("rstacc_no_upd",   32'(bus.num_update), 32'h0);
        send_const(12'h300, 1, 0);
        check("rstacc_num2", 32'(bus.num), 32'h300);

        // Reset mid-hold
        repeat (3) tick();
        check("rsthold_in_hold", 32'(bus.busy_hold), 32'h1);
        reset_n = 1'b0;
        #1;
        check("rsthold_num",  32'(bus.num), 32'h0);
        check("rsthold_busy", 32'(bus.busy_hold), 32'h0);
        check("rsthold_upd",  32'(bus.num_update), 32'h0);
        tick();
        reset_n = 1'b1;
        send_const(12'h050, 15, 0);
        check("rsthold_no_early", 32'(bus.num), 32'h0);
        send_const(12'h050, 1, 0);
        check("rsthold_num2", 32'(bus.num), 32'h050);
        check("rsthold_upd2", 32'(bus.num_update), 32'h1);

        // AVG_LOG2=0, HOLD_CYCLES=0: every sample publishes, never busy
        vals0[0] = 12'hABC;
        vals0[1] = 12'h001;
        vals0[2] = 12'hFFF;
        for (int i = 0; i < 3; i++) begin
            bus0.sample       = vals0[i];
            bus0.sample_valid = 1'b1;
            tick();
            check("a0_num",  32'(bus0.num), 32'(vals0[i]));
            check("a0_upd",  32'(bus0.num_update), 32'h1);
            check("a0_busy", 32'(bus0.busy_hold), 32'h0);
        end
        bus0.sample_valid = 1'b0;
        tick();
        check("a0_upd_off", 32'(bus0.num_update), 32'h0);
        check("a0_num_keep", 32'(bus0.num), 32'hFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_adc_display_averager
`default_nettype wire
